// File: rtl/cpu_mailbox_pkg.sv
// Shared definitions for the CPU path-planning mailbox (reader and starter sides).
//   MB_*        byte offsets of the mailbox words relative to the mailbox base
//   NODE_W      node id width
//   LEN_W       path length field width
//   mb_state_e  path reader FSM states
//   node_addr() address of node[idx] for a given mailbox base
package cpu_mailbox_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NODE_W = 5;
    localparam int unsigned LEN_W  = 6;

    localparam logic [ADDR_W-1:0] MB_START = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] MB_END   = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] MB_DONE  = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] MB_LEN   = 32'h0000_000C;
    localparam logic [ADDR_W-1:0] MB_PATH  = 32'h0000_0010;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POLL_REQ,
        ST_POLL_WAIT,
        ST_LEN_REQ,
        ST_LEN_WAIT,
        ST_NODE_REQ,
        ST_NODE_WAIT,
        ST_EMIT,
        ST_DONE,
        ST_ERR
    } mb_state_e;

    // Node words are packed one per 32-bit word after the path header.
    function automatic logic [ADDR_W-1:0] node_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [LEN_W-1:0]  idx);
        return base + MB_PATH + (ADDR_W'(idx) << 2);
    endfunction

endpackage

// File: rtl/cpu_mem_rd_port.sv
// Read port onto the external CPU data memory.
// The memory returns data exactly one cycle after the address is presented, so the
// address is registered on req_i, held for the following (wait) cycle, then parked at 0.
//   clk, rst_n     clock, asynchronous active-low reset
//   req_i, addr_i  request a read of addr_i (address appears on the bus next cycle)
//   mem_adr_o      registered external memory address
//   mem_rdata_i    external memory read data
//   rvalid_o       rdata_c carries the data for the last request this cycle
//   rdata_c        read data passthrough
module cpu_mem_rd_port
    import cpu_mailbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ADDR_W-1:0] mem_adr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_c
);

    logic [ADDR_W-1:0] adr_q;
    logic              pend_q;
    logic              rvalid_q;

    // Address register and one-cycle data alignment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr_q    <= '0;
            pend_q   <= 1'b0;
            rvalid_q <= 1'b0;
        end else begin
            pend_q   <= req_i;
            rvalid_q <= pend_q;
            if (req_i) begin
                adr_q <= addr_i;
            end else if (pend_q) begin
                adr_q <= adr_q;
            end else begin
                adr_q <= '0;
            end
        end
    end

    assign mem_adr_o = adr_q;
    assign rvalid_o  = rvalid_q;
    assign rdata_c   = mem_rdata_i;

endmodule

// File: rtl/cpu_path_reader.sv
// Read-back side of the CPU path-planning mailbox.
// After start, polls the done flag, reads the path length and streams each node
// to the navigation logic over valid/ready.
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse, begin polling (ignored while busy)
//   Ext_DataAdr   external memory read address (0 when not reading)
//   Ext_ReadData  external memory read data, one cycle after the address
//   node          current path node
//   node_valid    node holds a valid path entry
//   node_ready    consumer accepts node on node_valid && node_ready
//   path_len      path length, held from the length read until the next start
//   busy          high from start accepted until DONE/ERR completes
//   path_done     one-cycle pulse after the last node (or for an empty path)
//   error         sticky: poll timeout, oversize length or out-of-range node id
module cpu_path_reader #(
    parameter logic [31:0] BASE_ADR     = 32'h0200_0000,
    parameter int unsigned NODE_W       = cpu_mailbox_pkg::NODE_W,
    parameter int unsigned MAX_NODES    = 32,
    parameter int unsigned POLL_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [31:0]       Ext_DataAdr,
    input  logic [31:0]       Ext_ReadData,
    output logic [NODE_W-1:0] node,
    output logic              node_valid,
    input  logic              node_ready,
    output logic [5:0]        path_len,
    output logic              busy,
    output logic              path_done,
    output logic              error
);

    import cpu_mailbox_pkg::*;

    localparam int unsigned PC_W = $clog2(POLL_TIMEOUT + 1);

    mb_state_e         state_q, state_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [PC_W-1:0]   poll_q, poll_d;
    logic [NODE_W-1:0] node_q, node_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              rd_req_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data_c;

    cpu_mem_rd_port u_rd_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (rd_req_c),
        .addr_i      (rd_addr_c),
        .mem_adr_o   (Ext_DataAdr),
        .mem_rdata_i (Ext_ReadData),
        .rvalid_o    (rd_valid),
        .rdata_c     (rd_data_c)
    );

    // Next-state, counters and read requests.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        poll_d    = poll_q;
        node_d    = node_q;
        err_d     = err_q;
        rd_req_c  = 1'b0;
        rd_addr_c = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_POLL_REQ;
                    poll_d  = '0;
                    idx_d   = '0;
                    len_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_POLL_REQ: state_d = ST_POLL_WAIT;
            ST_POLL_WAIT: begin
                if (rd_valid) begin
                    if (rd_data_c != '0) begin
                        state_d = ST_LEN_REQ;
                    end else if (poll_q == PC_W'(POLL_TIMEOUT - 1)) begin
                        state_d = ST_ERR;
                    end else begin
                        poll_d  = poll_q + PC_W'(1);
                        state_d = ST_POLL_REQ;
                    end
                end
            end
            ST_LEN_REQ: state_d = ST_LEN_WAIT;
            ST_LEN_WAIT: begin
                if (rd_valid) begin
                    len_d = rd_data_c[LEN_W-1:0];
                    if (rd_data_c == '0) begin
                        state_d = ST_DONE;
                    end else if (rd_data_c > DATA_W'(MAX_NODES)) begin
                        state_d = ST_ERR;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_NODE_REQ;
                    end
                end
            end
            ST_NODE_REQ: state_d = ST_NODE_WAIT;
            ST_NODE_WAIT: begin
                if (rd_valid) begin
                    // Any bit above the node id field makes the id unrepresentable.
                    if ((rd_data_c >> NODE_W) != '0) begin
                        state_d = ST_ERR;
                    end else begin
                        node_d  = rd_data_c[NODE_W-1:0];
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (node_ready) begin
                    idx_d = idx_q + LEN_W'(1);
                    if (idx_q + LEN_W'(1) == len_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_NODE_REQ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end

        // Request is issued on entry to a REQ state so the address is on the bus during it.
        case (state_d)
            ST_POLL_REQ: begin
                rd_req_c  = 1'b1;
                rd_addr_c = BASE_ADR + MB_DONE;
            end
            ST_LEN_REQ: begin
                rd_req_c  = 1'b1;
                rd_addr_c = BASE_ADR + MB_LEN;
            end
            ST_NODE_REQ: begin
                rd_req_c  = 1'b1;
                rd_addr_c = node_addr(BASE_ADR, idx_d);
            end
            default: begin
                rd_req_c  = 1'b0;
                rd_addr_c = '0;
            end
        endcase

        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            poll_q  <= '0;
            node_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            poll_q  <= poll_d;
            node_q  <= node_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign node       = node_q;
    assign node_valid = valid_q;
    assign path_len   = len_q;
    assign busy       = busy_q;
    assign path_done  = done_q;
    assign error      = err_q;

endmodule

// File: tb/tb_cpu_path_reader.sv
// Self-checking bench for cpu_path_reader: mailbox memory model, node scoreboard,
// table of path scenarios plus hand-written latency and reset-abort sequences.
module tb_cpu_path_reader;

    localparam logic [31:0] BASE    = 32'h0200_0000;
    localparam int          TIMEOUT = 10;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] Ext_DataAdr;
    logic [31:0] Ext_ReadData;
    logic [4:0]  node;
    logic        node_valid;
    logic        node_ready;
    logic [5:0]  path_len;
    logic        busy;
    logic        path_done;
    logic        error;

    cpu_path_reader #(
        .BASE_ADR     (BASE),
        .NODE_W       (5),
        .MAX_NODES    (32),
        .POLL_TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .Ext_DataAdr  (Ext_DataAdr),
        .Ext_ReadData (Ext_ReadData),
        .node         (node),
        .node_valid   (node_valid),
        .node_ready   (node_ready),
        .path_len     (path_len),
        .busy         (busy),
        .path_done    (path_done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- mailbox memory model ----------------
    logic [31:0] mem_words [64];
    logic [31:0] len_word;
    logic [31:0] rd_q;
    logic [31:0] mem_off;
    int          zeros;
    int          poll_edges = 0;
    int          poll_base;

    assign mem_off      = Ext_DataAdr - BASE - 32'h10;
    assign Ext_ReadData = rd_q;

    // Address is held for REQ and WAIT, so each poll spans two edges on the done address.
    always @(posedge clk) begin
        if (Ext_DataAdr == BASE + 32'h8) begin
            rd_q       <= (((poll_edges - poll_base) / 2) >= zeros) ? 32'h1 : 32'h0;
            poll_edges <= poll_edges + 1;
        end else if (Ext_DataAdr == BASE + 32'hC) begin
            rd_q <= len_word;
        end else if (Ext_DataAdr >= BASE + 32'h10 && Ext_DataAdr < BASE + 32'h110) begin
            rd_q <= mem_words[mem_off[7:2]];
        end else begin
            rd_q <= 32'hDEAD_BEEF;
        end
    end

    // ---------------- output monitor ----------------
    logic [4:0] rx_q [$];
    int         done_cnt  = 0;
    int         valid_cyc = 0;
    int         unstable  = 0;
    int         adr_bad   = 0;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [4:0] prev_node  = '0;

    always @(negedge clk) begin
        if (node_valid) begin
            valid_cyc <= valid_cyc + 1;
            if (Ext_DataAdr != 32'h0) adr_bad <= adr_bad + 1;
            if (prev_valid && !prev_hs && node != prev_node) unstable <= unstable + 1;
            if (node_ready) rx_q.push_back(node);
        end
        if (path_done) done_cnt <= done_cnt + 1;
        prev_valid <= node_valid;
        prev_hs    <= node_valid && node_ready;
        prev_node  <= node;
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_miss = 0;
    int cur_id = -1;
    logic [4:0] exp_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (vec %0d): got %0d, required %0d", name, cur_id, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        n_vec++;
        n_miss++;
        $display("FAIL %s (vec %0d): wait bound expired, got busy=1, required busy=0", name, cur_id);
    endtask

    typedef struct {
        int          zeros;
        int          len;
        logic [31:0] w0, w1, w2, w3;
        int          stall_at;
        int          stall_len;
        int          restart_at;
        bit          exp_err;
        int          exp_done;
    } vec_t;

    task automatic load_path(input int len, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3, input int nz);
        for (int i = 0; i < 64; i++) begin
            mem_words[i] = 32'((i * 7 + 3) % 32);
        end
        mem_words[0] = w0;
        mem_words[1] = w1;
        mem_words[2] = w2;
        mem_words[3] = w3;
        len_word  = 32'(len);
        zeros     = nz;
        poll_base = poll_edges;
    endtask

    task automatic run_vec(input vec_t v);
        bit         timed_out;
        bit         finished;
        int         n_exp;
        int         exp_polls;
        logic [5:0] exp_len;
        int         rx_base, done_base, vbase, ubase, abase;
        int         stalled;
        int         n_rx;

        load_path(v.len, v.w0, v.w1, v.w2, v.w3, v.zeros);
        timed_out = (v.zeros >= TIMEOUT);
        exp_len   = timed_out ? 6'd0 : 6'(v.len);
        exp_polls = timed_out ? TIMEOUT : v.zeros + 1;
        exp_q.delete();
        if (!timed_out && v.len >= 1 && v.len <= 32) begin
            for (int i = 0; i < v.len; i++) begin
                if ((mem_words[i] >> 5) != 32'h0) break;
                exp_q.push_back(mem_words[i][4:0]);
            end
        end
        n_exp     = exp_q.size();
        rx_base   = rx_q.size();
        done_base = done_cnt;
        vbase     = valid_cyc;
        ubase     = unstable;
        abase     = adr_bad;
        stalled   = 0;
        finished  = 1'b0;

        @(posedge clk); #1;
        start      = 1'b1;
        node_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!busy) begin
                finished = 1'b1;
                break;
            end
            start = (c == v.restart_at);
            if (node_valid && (rx_q.size() - rx_base) == v.stall_at && stalled < v.stall_len) begin
                node_ready = 1'b0;
                stalled++;
            end else begin
                node_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        start      = 1'b0;
        node_ready = 1'b1;
        if (!finished) fail_bound("busy_wait");

        n_rx = rx_q.size() - rx_base;
        check("error", error, v.exp_err);
        check("path_done_pulses", done_cnt - done_base, v.exp_done);
        check("path_len", path_len, exp_len);
        check("polls", (poll_edges - poll_base) / 2, exp_polls);
        check("node_count", n_rx, n_exp);
        for (int i = 0; i < n_rx && exp_q.size() > 0; i++) begin
            check("node_value", rx_q[rx_base + i], exp_q.pop_front());
        end
        check("node_stable", unstable - ubase, 0);
        check("adr_in_emit", adr_bad - abase, 0);
        check("valid_cycles", valid_cyc - vbase,
              n_exp + ((v.stall_at >= 0 && v.stall_at < n_exp) ? v.stall_len : 0));
        check("valid_low_at_end", node_valid, 0);
    endtask

    // Counts negedges from the start-sampling edge to the first node_valid / path_done.
    task automatic measure(input int len, input logic [31:0] w0, input int exp_v, input int exp_d);
        int fv;
        int fd;
        fv = 0;
        fd = 0;
        load_path(len, w0, 32'h0, 32'h0, 32'h0, 0);
        node_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (node_valid && fv == 0) fv = k;
            if (path_done && fd == 0) fd = k;
            if (!busy) break;
        end
        check("first_valid_latency", fv, exp_v);
        check("path_done_latency", fd, exp_d);
    endtask

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{3, 3,  32'd4,  32'd9,    32'd17, 32'd0, -1, 0, -1, 1'b0, 1};
        vecs[1]  = '{3, 3,  32'd4,  32'd9,    32'd17, 32'd0,  1, 5, -1, 1'b0, 1};
        vecs[2]  = '{0, 0,  32'd0,  32'd0,    32'd0,  32'd0, -1, 0, -1, 1'b0, 1};
        vecs[3]  = '{1, 40, 32'd4,  32'd9,    32'd17, 32'd0, -1, 0, -1, 1'b1, 0};
        vecs[4]  = '{0, 3,  32'd4,  32'h25,   32'd17, 32'd0, -1, 0, -1, 1'b1, 0};
        vecs[5]  = '{1000, 3, 32'd4, 32'd9,   32'd17, 32'd0, -1, 0, -1, 1'b1, 0};
        vecs[6]  = '{0, 32, 32'd1,  32'd2,    32'd3,  32'd4, 31, 2, -1, 1'b0, 1};
        vecs[7]  = '{0, 33, 32'd1,  32'd2,    32'd3,  32'd4, -1, 0, -1, 1'b1, 0};
        vecs[8]  = '{2, 3,  32'd4,  32'd9,    32'd17, 32'd0, -1, 0,  4, 1'b0, 1};
        vecs[9]  = '{0, 2,  32'd31, 32'h20,   32'd0,  32'd0, -1, 0, -1, 1'b1, 0};
        vecs[10] = '{0, 1,  32'd0,  32'd0,    32'd0,  32'd0, -1, 0, -1, 1'b0, 1};
        vecs[11] = '{0, 3,  32'd4,  32'd9,    32'd17, 32'd0,  1, 3, 12, 1'b0, 1};

        rst_n      = 1'b0;
        start      = 1'b0;
        node_ready = 1'b0;
        load_path(0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        #12;
        check("rst_node_valid", node_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_path_done", path_done, 0);
        check("rst_error", error, 0);
        check("rst_adr", Ext_DataAdr, 0);
        check("rst_path_len", path_len, 0);
        check("rst_node", node, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // node_ready with no valid node must not disturb anything
        #1 node_ready = 1'b1;
        @(posedge clk); #1;
        check("idle_ready_no_effect", {busy, node_valid, path_done}, 0);

        for (int i = 0; i < 12; i++) begin
            cur_id = i;
            run_vec(vecs[i]);
        end

        cur_id = 100;
        measure(1, 32'd7, 7, 8);
        cur_id = 101;
        measure(0, 32'd0, 0, 5);

        // Reset while node 2 of 4 is being offered.
        begin
            int   rx_base;
            int   done_base;
            bit   found;
            vec_t fresh;
            cur_id = 200;
            load_path(4, 32'd1, 32'd2, 32'd3, 32'd4, 0);
            rx_base   = rx_q.size();
            found     = 1'b0;
            @(posedge clk); #1;
            start      = 1'b1;
            node_ready = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int c = 0; c < 200; c++) begin
                node_ready = ((rx_q.size() - rx_base) < 1);
                if (node_valid && node == 5'd2) begin
                    found = 1'b1;
                    break;
                end
                @(posedge clk); #1;
            end
            if (!found) fail_bound("reach_node2");
            check("pre_rst_path_len", path_len, 4);
            done_base = done_cnt;
            #2 rst_n = 1'b0;
            #1;
            check("abort_node_valid", node_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_adr", Ext_DataAdr, 0);
            check("abort_path_len", path_len, 0);
            check("abort_node", node, 0);
            repeat (2) @(posedge clk);
            #3 rst_n = 1'b1;
            node_ready = 1'b1;
            repeat (2) @(posedge clk);
            check("abort_no_path_done", done_cnt - done_base, 0);
            cur_id = 201;
            fresh = '{0, 4, 32'd10, 32'd11, 32'd12, 32'd13, -1, 0, -1, 1'b0, 1};
            run_vec(fresh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "watchdog");
    end

endmodule
